// File: rtl/mem_pkg.sv
// Shared types and default constants for the memory-stage controller.
package mem_pkg;

  localparam int unsigned DefBaseAddr   = 1024;
  localparam int unsigned DefDepth      = 64;
  localparam int unsigned DefWaitCycles = 4;
  localparam int unsigned CntW          = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// EXE-register inputs and MEM-register outputs of the memory stage.
interface mem_access_ctrl_if;

  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [31:0] alu_res_in;
  logic [31:0] val_rm_in;
  logic [3:0]  dest_in;

  logic        ready;
  logic [31:0] mem_result;
  logic        addr_err;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic [31:0] alu_res_out;
  logic [3:0]  dest_out;

  modport master (
    output wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, val_rm_in, dest_in,
    input  ready, mem_result, addr_err, wb_en_out, mem_r_en_out, alu_res_out, dest_out
  );

  modport slave (
    input  wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, val_rm_in, dest_in,
    output ready, mem_result, addr_err, wb_en_out, mem_r_en_out, alu_res_out, dest_out
  );

endinterface

// File: rtl/data_mem_array.sv
// Single-port synchronous data RAM, Depth x 32, registered read data.
module data_mem_array #(
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Write on we_i; read data registered every cycle from the current address.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory stage: fixed-latency load/store FSM driving the pipeline freeze.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DefBaseAddr,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       mem_result_q, mem_result_d;
  logic              addr_err_q, addr_err_d;

  logic              req, is_load, commit, ram_we, out_of_range;
  logic [31:0]       offset, idx, ram_rdata;

  assign bus.wb_en_out    = bus.wb_en_in;
  assign bus.mem_r_en_out = bus.mem_r_en_in;
  assign bus.alu_res_out  = bus.alu_res_in;
  assign bus.dest_out     = bus.dest_in;

  assign req     = bus.mem_r_en_in | bus.mem_w_en_in;
  // Store wins when both enables are set.
  assign is_load = bus.mem_r_en_in & ~bus.mem_w_en_in;

  assign offset       = bus.alu_res_in - BASE_ADDR;
  assign idx          = offset >> 2;
  assign out_of_range = (bus.alu_res_in < BASE_ADDR) | (idx >= DEPTH);

  // Reset on the commit edge aborts the write.
  assign ram_we = commit & bus.mem_w_en_in & ~out_of_range & ~rst;

  data_mem_array #(
    .Depth (DEPTH),
    .AddrW (AddrW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (idx[AddrW-1:0]),
    .wdata_i (bus.val_rm_in),
    .rdata_o (ram_rdata)
  );

  // State, wait counter and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      mem_result_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_result_q <= mem_result_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Next-state, countdown and commit decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    commit       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StAccess;
          cnt_d   = CntW'(WAIT_CYCLES - 1);
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // RAM read data was latched while the address was already stable.
    mem_result_d = mem_result_q;
    if (commit && is_load) begin
      mem_result_d = out_of_range ? '0 : ram_rdata;
    end
    addr_err_d = commit & out_of_range;
  end

  assign bus.ready      = ~((state_q == StIdle) & req) & (state_q != StAccess);
  assign bus.mem_result = mem_result_q;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl against a behavioural memory model.
module tb_mem_access_ctrl;

  localparam int unsigned Base  = 1024;
  localparam int unsigned Depth = 64;
  localparam int unsigned Wait  = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .BASE_ADDR   (Base),
    .DEPTH       (Depth),
    .WAIT_CYCLES (Wait)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [31:0] ref_mem [Depth];
  logic [31:0] ref_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Presents one op at an IDLE negedge, waits through the stall, checks DONE, returns at the
  // following negedge with inputs still held.
  task automatic run_op(input string tag, input logic r, input logic w,
                        input logic [31:0] addr, input logic [31:0] data);
    int          low;
    int          exp_low;
    logic        oor;
    int unsigned widx;
    oor     = (addr < Base) || (((addr - Base) / 4) >= Depth);
    widx    = oor ? 0 : (addr - Base) / 4;
    exp_low = (r || w) ? int'(Wait) + 1 : 0;
    if (w) begin
      if (!oor) ref_mem[widx] = data;
    end else if (r) begin
      ref_res = oor ? 32'h0 : ref_mem[widx];
    end

    bus.mem_r_en_in = r;
    bus.mem_w_en_in = w;
    bus.wb_en_in    = r;
    bus.alu_res_in  = addr;
    bus.val_rm_in   = data;
    bus.dest_in     = addr[5:2];
    #1;
    check({tag, ".alu_out"}, bus.alu_res_out, addr);
    check({tag, ".ctl_out"}, {26'h0, bus.dest_out, bus.wb_en_out, bus.mem_r_en_out},
          {26'h0, addr[5:2], r, r});

    low = 0;
    while (bus.ready !== 1'b1 && low < 40) begin
      low++;
      @(negedge clk);
    end
    check({tag, ".stall"}, 32'(low), 32'(exp_low));
    check({tag, ".addr_err"}, {31'h0, bus.addr_err}, {31'h0, oor & (r | w)});
    check({tag, ".result"}, bus.mem_result, ref_res);
    @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    bus.wb_en_in    = 1'b0;
    bus.mem_r_en_in = 1'b0;
    bus.mem_w_en_in = 1'b0;
    bus.alu_res_in  = '0;
    bus.val_rm_in   = '0;
    bus.dest_in     = '0;
    ref_res         = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.ready", {31'h0, bus.ready}, 32'h1);
    check("rst.result", bus.mem_result, 32'h0);
    check("rst.addr_err", {31'h0, bus.addr_err}, 32'h0);
    @(negedge clk);

    // Non-memory op: no stall, pass-through only.
    bus.wb_en_in   = 1'b1;
    bus.alu_res_in = 32'h55;
    bus.dest_in    = 4'h3;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("nonmem.ready", {31'h0, bus.ready}, 32'h1);
      check("nonmem.alu_out", bus.alu_res_out, 32'h55);
      check("nonmem.result", bus.mem_result, 32'h0);
      @(negedge clk);
    end

    for (int i = 0; i < int'(Depth); i++) begin
      run_op($sformatf("fill%0d", i), 1'b0, 1'b1, Base + 4 * i, $urandom());
    end

    run_op("st1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    run_op("ld1028", 1'b1, 1'b0, 32'd1028, 32'h0);
    check("ld1028.value", bus.mem_result, 32'hDEADBEEF);

    run_op("ld_below", 1'b1, 1'b0, 32'd1000, 32'h0);
    run_op("ld_above", 1'b1, 1'b0, Base + 4 * Depth, 32'h0);
    run_op("ld_last", 1'b1, 1'b0, Base + 4 * (Depth - 1), 32'h0);
    run_op("ld_wrap", 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);

    // Held request: second op starts from the single IDLE cycle after DONE.
    run_op("b2b_a", 1'b1, 1'b0, 32'd1028, 32'h0);
    run_op("b2b_b", 1'b1, 1'b0, 32'd1028, 32'h0);
    bus.mem_r_en_in = 1'b0;
    #1;
    check("b2b.no_dup", {31'h0, bus.ready}, 32'h1);
    @(negedge clk);

    // Reset during the second ACCESS cycle aborts the store.
    bus.mem_w_en_in = 1'b1;
    bus.alu_res_in  = 32'd1032;
    bus.val_rm_in   = 32'h12345678;
    @(negedge clk);
    check("rstmid.acc1", {31'h0, bus.ready}, 32'h0);
    @(negedge clk);
    check("rstmid.acc2", {31'h0, bus.ready}, 32'h0);
    rst             = 1'b1;
    bus.mem_w_en_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    ref_res = '0;
    check("rstmid.ready", {31'h0, bus.ready}, 32'h1);
    check("rstmid.result", bus.mem_result, 32'h0);
    check("rstmid.addr_err", {31'h0, bus.addr_err}, 32'h0);
    @(negedge clk);
    run_op("ld1032", 1'b1, 1'b0, 32'd1032, 32'h0);

    run_op("both1036", 1'b1, 1'b1, 32'd1036, 32'hA5A5A5A5);
    run_op("ld1036", 1'b1, 1'b0, 32'd1036, 32'h0);
    check("ld1036.value", bus.mem_result, 32'hA5A5A5A5);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int unsigned sel;
      sel = $urandom_range(0, 3);
      case ($urandom_range(0, 7))
        0:       a = $urandom_range(0, Base - 1);
        1:       a = Base + 4 * Depth + $urandom_range(0, 255);
        2:       a = $urandom();
        default: a = Base + 4 * $urandom_range(0, Depth - 1) + $urandom_range(0, 3);
      endcase
      run_op($sformatf("rnd%0d", i), sel[0], sel[1], a, $urandom());
    end

    bus.mem_r_en_in = 1'b0;
    bus.mem_w_en_in = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
